// File: rtl/dataflow_channel_arbiter_pkg.sv
// Shared types and constants for the dataflow channel arbiter.
// Holds the FSM encoding, counter width and a clog2 helper.
package dataflow_channel_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  localparam int COUNT_WIDTH = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dataflow_channel_arbiter_rr_priority_picker.sv
// Round-robin picker: first eligible index at or after the pointer.
// Purely combinational, wraps modulo N.
import dataflow_channel_arbiter_pkg::*;

module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  int j;

  // Scan from farthest offset down so the nearest eligible wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (elig_i[j]) begin
        idx_o = W'(j);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dataflow_channel_arbiter.sv
// Shares one pull-handshake producer among NUM_REQ requesters.
// Round-robin grants, per-requester counters, optional ack watchdog.
import dataflow_channel_arbiter_pkg::*;

module dataflow_channel_arbiter #(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int         GW         = clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             en_mask,
  output logic                           req_l,
  input  logic                           ack_l,
  input  logic [DATA_WIDTH-1:0]          din,
  input  logic [NUM_REQ-1:0]             req_r,
  output logic [NUM_REQ-1:0]             ack_r,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic [GW-1:0]                  grant_id,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [COUNT_WIDTH*NUM_REQ-1:0] grant_count
);

  arb_state_e              state_q, state_d;
  logic [GW-1:0]           gid_q, gid_d;
  logic [GW-1:0]           rr_q, rr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    terr_q, terr_d;
  logic [31:0]             wd_q, wd_d;
  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_REQ];
  logic                    inc;
  logic [GW-1:0]           pick_idx;
  logic                    pick_vld;
  logic [GW-1:0]           nxt;

  rr_priority_picker #(
    .N (NUM_REQ),
    .W (GW)
  ) u_pick (
    .elig_i (req_r & en_mask),
    .ptr_i  (rr_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  assign nxt = (gid_q == GW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      dout_q  <= INIT_VALUE;
      terr_q  <= 1'b0;
      wd_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      dout_q  <= dout_d;
      terr_q  <= terr_d;
      wd_q    <= wd_d;
      if (inc) cnt_q[gid_q] <= cnt_q[gid_q] + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    dout_d  = dout_q;
    terr_d  = terr_q;
    wd_d    = wd_q;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gid_d   = pick_idx;
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_l) begin
          dout_d  = din;
          inc     = 1'b1;
          wd_d    = '0;
          state_d = HOLD;
        end else begin
          wd_d = wd_q + 1'b1;
          if (TIMEOUT != 0 && wd_d == 32'(TIMEOUT)) begin
            terr_d  = 1'b1;
            wd_d    = '0;
            rr_d    = nxt;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        rr_d    = nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_l       = (state_q == WAIT);
    busy        = (state_q != IDLE);
    ack_r       = '0;
    if (state_q == HOLD) ack_r[gid_q] = 1'b1;
    dout        = dout_q;
    grant_id    = gid_q;
    timeout_err = terr_q;
    for (int i = 0; i < NUM_REQ; i++)
      grant_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: doc/dataflow_channel_arbiter.md
Name: dataflow_channel_arbiter

Overview:
- Shares one upstream producer channel among NUM_REQ downstream operator inputs. Uses the graph's pull handshake: the consumer holds req, and the provider answers with a one-cycle ack plus valid data.
- Grants are round-robin. Each accepted token goes to exactly one requester; this is not a broadcast.
- Sits between a producer (or an in/reg operator output) and several async operators contending for the same stream.
- Adds a per-requester grant counter for throughput benches and a watchdog on the upstream ack.

Parameters:
- DATA_WIDTH, 32, data bus width.
- NUM_REQ, 4, number of downstream requesters; legal range 2..16.
- TIMEOUT, 0, max cycles to wait for ack_l; 0 disables the watchdog.
- INIT_VALUE, 0, reset value of dout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- en_mask  in  NUM_REQ  per-requester enable; a 0 bit makes that requester ineligible for new grants.
- req_l  out  1  request to the upstream provider.
- ack_l  in  1  upstream ack pulse; din is valid while it is high.
- din  in  DATA_WIDTH  upstream data.
- req_r  in  NUM_REQ  requester level requests.
- ack_r  out  NUM_REQ  one-hot ack pulses.
- dout  out  DATA_WIDTH  data of the last grant; holds until the next grant.
- grant_id  out  clog2(NUM_REQ)  current or last grantee.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky watchdog flag.
- grant_count  out  32*NUM_REQ  packed per-requester grant counters.

Behaviour:
- Reset (rst==0 at posedge) values:
  - state = IDLE; req_l = 0; ack_r = 0; dout = INIT_VALUE.
  - grant_id = 0; rr pointer = 0; all grant_count = 0; timeout_err = 0; watchdog counter = 0.
  - Reset mid-transaction aborts it. An ack_l arriving after reset is ignored.
- Eligible set: req_r & en_mask.
- IDLE:
  - If the eligible set is non-empty, pick the first eligible index at or after the rr pointer, wrapping modulo NUM_REQ.
  - Register grant_id and set req_l = 1. Next state = WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Hold req_l = 1 until ack_l is sampled high.
  - On ack_l high:
    - req_l = 0; dout = din.
    - ack_r[grant_id] = 1 for exactly one cycle; grant_count[grant_id] += 1 (wraps at 2^32).
    - Next state = HOLD.
  - Watchdog counter increments each WAIT cycle. If TIMEOUT != 0 and the counter reaches TIMEOUT with no ack:
    - req_l = 0; timeout_err = 1; counter cleared.
    - rr pointer = grant_id + 1; next state = IDLE.
    - No ack_r is issued.
- HOLD (1 cycle):
  - ack_r = 0; req_r is ignored, because the grantee drops req one edge after seeing ack.
  - rr pointer = (grant_id + 1) mod NUM_REQ. Next state = IDLE.
- Latency: req_r rising at edge t gives req_l at t+1. With an immediate upstream ack at t+2, ack_r and dout are valid at t+3. Best-case throughput is 1 token per 4 cycles, matching the producer's ack cadence.
- ack_l outside WAIT is ignored, with no counter or data change.
- A grantee that drops req_r during WAIT still receives the ack_r pulse and the token is consumed. A grantee masked during WAIT is likewise still served. Masking affects only IDLE selection.
- ack_r is never multi-hot. At most one req_l transaction is outstanding.
- timeout_err clears only on reset.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2);
  - the COUNT_WIDTH=32 constant;
  - a clog2 helper function.
- One natural sub-module, rr_priority_picker: combinational; takes the eligible vector and the pointer and returns the index plus a valid flag.

Test Plan:
- Single requester: req_r=4'b0001, producer with fail_rate 0 and din counting from 0 → ack_r[0] pulses every 4 cycles, dout = 0,1,2,…; grant_count[0] = 100 after 100 tokens.
- All four requesting continuously → grant order 0,1,2,3,0,…; after 400 tokens each grant_count = 100 and the dout values seen by each requester are disjoint.
- en_mask=4'b1011 with all requesting → requester 2 never acked; others get equal counts; set the mask bit mid-run → requester 2 served on its next rr turn.
- TIMEOUT=8 with the producer never acking → req_l drops after 8 WAIT cycles and timeout_err = 1 stays set; a later real ack_l is ignored while in IDLE.
- Reset asserted in WAIT, and a stray ack_l the cycle after reset is released → no ack_r, counters stay 0, dout = INIT_VALUE.
- Requester 1 drops req_r during WAIT → it still gets the ack_r pulse; its grant_count increments; the next grant goes to requester 2.
